test_article: RTL and testbench
===============================

# test_article

Minimal 16-bit MCU core used as the test article for register-file and bus bring-up benches. It fetches instructions from an external ROM port, steps each instruction through a fixed four-phase sequencer, and operates on a 16×16-bit register file. It drives an external asynchronous memory bus, LEDs, DIP-switch input and an interrupt-pending latch. It is the top of the core-level simulation hierarchy; the UART pins are reserved.

## Interface
- No parameters.
- PIN_CLK_X1  in  1  system clock; all state updates on the rising edge.
- PIN_RESET  in  1  synchronous, active-high reset.
- FETCH, DECODE, EXECUTE, COMMIT  out  1 each  one-hot phase indicators.
- ROM_ADDR  out  16  instruction address; always equals PC.
- ROM_DOUT  in  16  instruction word; combinationally valid for ROM_ADDR.
- PIN_ADDR_BUS  out  16  external data address.
- PIN_DATA_BUS  inout  16  external data; hi-Z unless storing.
- PIN_RDN, PIN_WR0N, PIN_WR1N  out  1 each  read strobe, low-byte write strobe, high-byte write strobe; all active-low.
- PIN_INT0..PIN_INT6  in  1 each  asynchronous interrupt requests.
- PIN_RXD  in  1  reserved, ignored.
- PIN_TXD  out  1  reserved, constant 1.
- PIN_DIPSW  in  4  switch inputs.
- PIN_LED  out  8  LED register.

## Operation
- Instruction fields: op = [15:12], rd = [11:8], rs = [7:4], imm8 = [7:0], imm12 = [11:0].
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd = {8'h00, imm8}.
  - 2 LDH: rd[15:8] = imm8; rd[7:0] unchanged.
  - 3 MOV: rd = rs.
  - 4 ADD, 5 SUB: rd = rd ± rs, modulo 2^16, no flags.
  - 6 AND, 7 OR, 8 XOR: bitwise on rd and rs into rd.
  - 9 LD: rd = mem[rs].
  - A ST: mem[rs] = rd, both bytes.
  - B OUT: PIN_LED = rd[7:0].
  - C IN: imm8[0] = 0 gives rd = {12'h0, PIN_DIPSW}; imm8[0] = 1 gives rd = {9'h0, pending[6:0]} and clears the pending bits that were read.
  - D JMP: PC = {4'h0, imm12}.
  - E JZ: if rd == 0 then PC = rs, else PC + 1.
  - F HALT: the sequencer stops; it leaves this state only on reset.
- Register file: 16 entries × 16 bits, two combinational read ports (rd, rs), one write port written only in COMMIT. All registers clear to 0 on reset. r0 is an ordinary register.
- PC arithmetic is 16-bit and wraps from FFFF to 0000.
- Interrupts:
  - Each PIN_INTn passes through a two-flop synchronizer.
  - A synchronized rising edge sets pending[n].
  - If a set and a clear of the same bit occur in the same cycle, the set wins.

## Timing
- Sequencer order: FETCH → DECODE → EXECUTE → COMMIT → FETCH. Each phase lasts exactly one clock, so an instruction takes 4 cycles.
- Reset state: phase = FETCH (FETCH = 1, other phase outputs 0), PC = 0, LED = 0, pending = 0, PIN_ADDR_BUS = 0, strobes high, data bus hi-Z, TXD = 1.
- Reset taken in any phase, including HALT, returns the core to the reset state on the next edge.
- FETCH: IR latches ROM_DOUT at the end of the cycle.
- DECODE: operands are read from the register file into A/B latches.
- EXECUTE:
  - ALU result is latched.
  - LD: PIN_ADDR_BUS = rs and PIN_RDN = 0; the data bus is sampled at the end of the cycle.
  - ST: PIN_ADDR_BUS = rs, PIN_DATA_BUS = rd, and PIN_WR0N = PIN_WR1N = 0.
- COMMIT:
  - Register write, LED write and pending clear take effect.
  - PC updates to PC + 1 or the jump target.
  - ST keeps address and data driven with strobes high, giving one cycle of hold.
- Outside LD/ST: PIN_ADDR_BUS = 0, strobes high, data bus hi-Z.
- HALT: all four phase outputs go 0 from the cycle after HALT's COMMIT onward.

## Configuration
- TEST_ARTICLE_INT_EN defined: synchronizers and pending latch are built as described above.
- TEST_ARTICLE_INT_EN undefined: PIN_INTn are ignored and IN with imm8[0] = 1 returns 0.

## Structure
- Shared package holds opcode constants, the phase encoding, and the IN selector codes.
- One natural sub-module: register_file (16×16, 2R/1W, synchronous reset, PIN_CLK_X1 and PIN_RESET).
- Sequencer, ALU, bus and I/O logic stay in the top level.

## Test plan
- ROM_DOUT = 0000, reset held 2 cycles then released: phases cycle with FETCH first; ROM_ADDR steps 0, 1, 2… every 4 cycles; LED = 00; TXD = 1.
- LDI r1,0x34 then LDH r1,0x12 then OUT r1: after the OUT COMMIT, PIN_LED = 34.
- LDI r2,5; LDI r3,7; ADD r2,r3; OUT r2 gives LED = 0C. SUB 0 − 1 gives FFFF, checked via LDH/OUT paths.
- ST r1 to [r4] with r1 = 1234 and r4 = 0040: in EXECUTE, ADDR = 0040, DATA = 1234, WR0N = WR1N = 0. LD from a bus driving BEEF gives r5 = BEEF.
- Pulse PIN_INT3 with TEST_ARTICLE_INT_EN defined: IN r6,1 gives r6 = 0008; an immediately repeated IN returns 0000.
- JMP 0x010, HALT at 0x010, then reset pulse: ROM_ADDR holds 0010 with phase outputs 0; after reset, PC = 0000 and FETCH = 1.

Source files
------------

// File: rtl/test_article_pkg.sv
// Shared definitions for the test_article MCU core: opcodes, phase
// encoding, IN selector codes and a small decode helper.
package test_article_pkg;

  // Opcode field values (instruction bits [15:12])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDH  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_IN   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // IN source selector carried in imm8[0]
  localparam logic IN_SEL_DIPSW   = 1'b0;
  localparam logic IN_SEL_PENDING = 1'b1;

  // One-hot sequencer phases; PH_HALT drives all phase outputs low
  typedef enum logic [4:0] {
    PH_FETCH   = 5'b00001,
    PH_DECODE  = 5'b00010,
    PH_EXECUTE = 5'b00100,
    PH_COMMIT  = 5'b01000,
    PH_HALT    = 5'b10000
  } phase_e;

  // True for opcodes that write rd during COMMIT
  function automatic logic writes_rd(input logic [3:0] op);
    logic w;
    case (op)
      OP_LDI, OP_LDH, OP_MOV, OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_XOR, OP_LD, OP_IN: w = 1'b1;
      default:                             w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/test_article_register_file.sv
// 16 x 16-bit register file: two combinational read ports, one write
// port, all entries cleared by synchronous reset.
module test_article_register_file
  import test_article_pkg::*;
(
  input  logic        PIN_CLK_X1,
  input  logic        PIN_RESET,
  input  logic [3:0]  rd_addr,
  input  logic [3:0]  rs_addr,
  output logic [15:0] rd_data,
  output logic [15:0] rs_data,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data
);

  logic [15:0] regs_q [16];
  logic [15:0] regs_d [16];

  // Read ports are plain array lookups
  always_comb begin
    rd_data = regs_q[rd_addr];
    rs_data = regs_q[rs_addr];
  end

  // Next-state of the array: update a single entry when writing
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end else begin
      regs_d = regs_q;
    end
  end

  // Storage flops with synchronous clear
  always_ff @(posedge PIN_CLK_X1) begin
    if (PIN_RESET) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/test_article.sv
// test_article: minimal 16-bit MCU core with a four-phase sequencer,
// external ROM port, async memory bus, LEDs, DIP switches and interrupts.
// Optional feature macro: TEST_ARTICLE_INT_EN builds the interrupt
// synchronizers and pending latch; without it the interrupt pins are
// ignored and IN from the pending source returns zero.
module test_article
  import test_article_pkg::*;
(
  input  logic        PIN_CLK_X1,
  input  logic        PIN_RESET,
  output logic        FETCH,
  output logic        DECODE,
  output logic        EXECUTE,
  output logic        COMMIT,
  output logic [15:0] ROM_ADDR,
  input  logic [15:0] ROM_DOUT,
  output logic [15:0] PIN_ADDR_BUS,
  inout  wire  [15:0] PIN_DATA_BUS,
  output logic        PIN_RDN,
  output logic        PIN_WR0N,
  output logic        PIN_WR1N,
  input  logic        PIN_INT0,
  input  logic        PIN_INT1,
  input  logic        PIN_INT2,
  input  logic        PIN_INT3,
  input  logic        PIN_INT4,
  input  logic        PIN_INT5,
  input  logic        PIN_INT6,
  input  logic        PIN_RXD,
  output logic        PIN_TXD,
  input  logic [3:0]  PIN_DIPSW,
  output logic [7:0]  PIN_LED
);

  phase_e      phase_q, phase_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] res_q, res_d;
  logic [7:0]  led_q, led_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic        doe_q, doe_d;
  logic        rdn_q, rdn_d;
  logic        wrn_q, wrn_d;

  logic [3:0]  op_s, rd_s, rs_s;
  logic [7:0]  imm8_s;
  logic [11:0] imm12_s;
  logic [15:0] rf_rd_data_s, rf_rs_data_s;
  logic        rf_we_s;
  logic [6:0]  pend_clr_s;
  logic [6:0]  pending_s;
  logic [6:0]  int_raw_s;
  logic        unused_pins_s;

  assign op_s    = ir_q[15:12];
  assign rd_s    = ir_q[11:8];
  assign rs_s    = ir_q[7:4];
  assign imm8_s  = ir_q[7:0];
  assign imm12_s = ir_q[11:0];

  assign int_raw_s = {PIN_INT6, PIN_INT5, PIN_INT4, PIN_INT3,
                      PIN_INT2, PIN_INT1, PIN_INT0};
  assign unused_pins_s = PIN_RXD;

  test_article_register_file u_regs (
    .PIN_CLK_X1 (PIN_CLK_X1),
    .PIN_RESET  (PIN_RESET),
    .rd_addr    (rd_s),
    .rs_addr    (rs_s),
    .rd_data    (rf_rd_data_s),
    .rs_data    (rf_rs_data_s),
    .wr_en      (rf_we_s),
    .wr_addr    (rd_s),
    .wr_data    (res_q)
  );

`ifdef TEST_ARTICLE_INT_EN
  logic [6:0] sync1_q, sync2_q, prev_q, pending_q, pending_d;

  // Pending latch: a new synchronized rising edge overrides a same-cycle clear
  always_comb begin
    pending_d = (pending_q & ~pend_clr_s) | (sync2_q & ~prev_q);
  end

  // Two-flop synchronizers, edge-detect history and pending register
  always_ff @(posedge PIN_CLK_X1) begin
    if (PIN_RESET) begin
      sync1_q   <= 7'h00;
      sync2_q   <= 7'h00;
      prev_q    <= 7'h00;
      pending_q <= 7'h00;
    end else begin
      sync1_q   <= int_raw_s;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
    end
  end

  assign pending_s = pending_q;
`else
  logic unused_int_s;
  assign unused_int_s = ^{int_raw_s, pend_clr_s};
  assign pending_s    = 7'h00;
`endif

  // Sequencer, ALU, bus and I/O next-state; bus pins are set up one phase
  // early so every pin comes straight from a flop
  always_comb begin
    phase_d    = phase_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    led_d      = led_q;
    addr_d     = 16'h0000;
    dout_d     = dout_q;
    doe_d      = 1'b0;
    rdn_d      = 1'b1;
    wrn_d      = 1'b1;
    rf_we_s    = 1'b0;
    pend_clr_s = 7'h00;
    case (phase_q)
      PH_FETCH: begin
        ir_d    = ROM_DOUT;
        phase_d = PH_DECODE;
      end
      PH_DECODE: begin
        a_d = rf_rd_data_s;
        b_d = rf_rs_data_s;
        if (op_s == OP_LD) begin
          addr_d = rf_rs_data_s;
          rdn_d  = 1'b0;
        end else if (op_s == OP_ST) begin
          addr_d = rf_rs_data_s;
          dout_d = rf_rd_data_s;
          doe_d  = 1'b1;
          wrn_d  = 1'b0;
        end else begin
          addr_d = 16'h0000;
        end
        phase_d = PH_EXECUTE;
      end
      PH_EXECUTE: begin
        case (op_s)
          OP_LDI:  res_d = {8'h00, imm8_s};
          OP_LDH:  res_d = {imm8_s, a_q[7:0]};
          OP_MOV:  res_d = b_q;
          OP_ADD:  res_d = a_q + b_q;
          OP_SUB:  res_d = a_q - b_q;
          OP_AND:  res_d = a_q & b_q;
          OP_OR:   res_d = a_q | b_q;
          OP_XOR:  res_d = a_q ^ b_q;
          OP_LD:   res_d = PIN_DATA_BUS;
          OP_IN: begin
            if (imm8_s[0] == IN_SEL_PENDING) begin
              res_d = {9'h000, pending_s};
            end else begin
              res_d = {12'h000, PIN_DIPSW};
            end
          end
          default: res_d = res_q;
        endcase
        // Store holds address and data one more cycle with strobes released
        if (op_s == OP_ST) begin
          addr_d = addr_q;
          doe_d  = 1'b1;
        end else begin
          addr_d = 16'h0000;
        end
        phase_d = PH_COMMIT;
      end
      PH_COMMIT: begin
        rf_we_s = writes_rd(op_s);
        if (op_s == OP_OUT) begin
          led_d = a_q[7:0];
        end else begin
          led_d = led_q;
        end
        if ((op_s == OP_IN) && (imm8_s[0] == IN_SEL_PENDING)) begin
          pend_clr_s = res_q[6:0];
        end else begin
          pend_clr_s = 7'h00;
        end
        case (op_s)
          OP_JMP:  pc_d = {4'h0, imm12_s};
          OP_JZ:   pc_d = (a_q == 16'h0000) ? b_q : (pc_q + 16'h0001);
          OP_HALT: pc_d = pc_q;
          default: pc_d = pc_q + 16'h0001;
        endcase
        if (op_s == OP_HALT) begin
          phase_d = PH_HALT;
        end else begin
          phase_d = PH_FETCH;
        end
      end
      PH_HALT: begin
        phase_d = PH_HALT;
      end
      default: begin
        phase_d = PH_FETCH;
      end
    endcase
  end

  // Core state register with synchronous reset
  always_ff @(posedge PIN_CLK_X1) begin
    if (PIN_RESET) begin
      phase_q <= PH_FETCH;
      pc_q    <= 16'h0000;
      ir_q    <= 16'h0000;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      res_q   <= 16'h0000;
      led_q   <= 8'h00;
      addr_q  <= 16'h0000;
      dout_q  <= 16'h0000;
      doe_q   <= 1'b0;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      led_q   <= led_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
    end
  end

  // Output mapping straight from state flops
  always_comb begin
    FETCH        = (phase_q == PH_FETCH);
    DECODE       = (phase_q == PH_DECODE);
    EXECUTE      = (phase_q == PH_EXECUTE);
    COMMIT       = (phase_q == PH_COMMIT);
    ROM_ADDR     = pc_q;
    PIN_ADDR_BUS = addr_q;
    PIN_RDN      = rdn_q;
    PIN_WR0N     = wrn_q;
    PIN_WR1N     = wrn_q;
    PIN_TXD      = 1'b1;
    PIN_LED      = led_q;
  end

  assign PIN_DATA_BUS = doe_q ? dout_q : 16'hzzzz;

endmodule

// File: tb/tb_test_article.sv
// Directed self-checking bench for test_article: runs a small ROM program
// and checks phases, PC, LEDs, bus cycles, interrupts, jumps and HALT.
module tb_test_article;

  logic        clk;
  logic        rst;
  logic        f_o, d_o, e_o, c_o;
  logic [15:0] rom_addr;
  logic [15:0] rom_dout;
  logic [15:0] addr_bus;
  wire  [15:0] data_bus;
  logic        rdn, wr0n, wr1n;
  logic [6:0]  ints;
  logic        txd;
  logic [3:0]  dipsw;
  logic [7:0]  led;
  logic [15:0] rom [256];

  int n_checks;
  int n_fail;

  test_article dut (
    .PIN_CLK_X1   (clk),
    .PIN_RESET    (rst),
    .FETCH        (f_o),
    .DECODE       (d_o),
    .EXECUTE      (e_o),
    .COMMIT       (c_o),
    .ROM_ADDR     (rom_addr),
    .ROM_DOUT     (rom_dout),
    .PIN_ADDR_BUS (addr_bus),
    .PIN_DATA_BUS (data_bus),
    .PIN_RDN      (rdn),
    .PIN_WR0N     (wr0n),
    .PIN_WR1N     (wr1n),
    .PIN_INT0     (ints[0]),
    .PIN_INT1     (ints[1]),
    .PIN_INT2     (ints[2]),
    .PIN_INT3     (ints[3]),
    .PIN_INT4     (ints[4]),
    .PIN_INT5     (ints[5]),
    .PIN_INT6     (ints[6]),
    .PIN_RXD      (1'b1),
    .PIN_TXD      (txd),
    .PIN_DIPSW    (dipsw),
    .PIN_LED      (led)
  );

  // Memory model answers every read with BEEF
  assign data_bus = (rdn == 1'b0) ? 16'hBEEF : 16'hzzzz;

  always_comb begin
    rom_dout = (rom_addr[15:8] == 8'h00) ? rom[rom_addr[7:0]] : 16'h0000;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step_instr();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic phases(input string tag, input logic [3:0] exp);
    check(tag, {12'h000, f_o, d_o, e_o, c_o}, {12'h000, exp});
  endtask

  // Store with [r4] = 0040: write in EXECUTE, one cycle of hold in COMMIT
  task automatic st_check(input string tag, input logic [15:0] exp_data);
    tick(); tick();
    check({tag, "_ex_addr"}, addr_bus, 16'h0040);
    check({tag, "_ex_data"}, data_bus, exp_data);
    check({tag, "_ex_strb"}, {13'h0, rdn, wr0n, wr1n}, 16'h0004);
    tick();
    check({tag, "_hold_data"}, data_bus, exp_data);
    check({tag, "_hold_strb"}, {13'h0, rdn, wr0n, wr1n}, 16'h0007);
    tick();
    check({tag, "_idle_addr"}, addr_bus, 16'h0000);
  endtask

  logic [15:0] exp_int;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ints     = 7'h00;
    dipsw    = 4'h5;
`ifdef TEST_ARTICLE_INT_EN
    exp_int  = 16'h0008;
`else
    exp_int  = 16'h0000;
`endif
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h1134;  // LDI r1,34
    rom[8'h01] = 16'h2112;  // LDH r1,12
    rom[8'h02] = 16'hB100;  // OUT r1
    rom[8'h03] = 16'h1205;  // LDI r2,5
    rom[8'h04] = 16'h1307;  // LDI r3,7
    rom[8'h05] = 16'h4230;  // ADD r2,r3
    rom[8'h06] = 16'hB200;  // OUT r2
    rom[8'h07] = 16'h1440;  // LDI r4,40
    rom[8'h08] = 16'hA140;  // ST r1,[r4]
    rom[8'h09] = 16'h9540;  // LD r5,[r4]
    rom[8'h0A] = 16'hA540;  // ST r5,[r4]
    rom[8'h0B] = 16'h1801;  // LDI r8,1
    rom[8'h0C] = 16'h5780;  // SUB r7,r8 (0 - 1)
    rom[8'h0D] = 16'hA740;  // ST r7,[r4]
    rom[8'h0E] = 16'hB700;  // OUT r7
    rom[8'h0F] = 16'hD020;  // JMP 020
    rom[8'h10] = 16'hF000;  // HALT
    rom[8'h20] = 16'hC900;  // IN r9,0 (switches)
    rom[8'h21] = 16'hA940;  // ST r9,[r4]
    rom[8'h22] = 16'hC601;  // IN r6,1 (pending)
    rom[8'h23] = 16'hA640;  // ST r6,[r4]
    rom[8'h24] = 16'hC601;  // IN r6,1 again
    rom[8'h25] = 16'hA640;  // ST r6,[r4]
    rom[8'h26] = 16'h1A30;  // LDI r10,30
    rom[8'h27] = 16'hE7A0;  // JZ r7,r10 (not taken)
    rom[8'h28] = 16'hE0A0;  // JZ r0,r10 (taken)
    rom[8'h29] = 16'hF000;  // HALT (only if JZ misbehaves)
    rom[8'h30] = 16'hD010;  // JMP 010

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    phases("rst_phase", 4'b1000);
    check("rst_pc", rom_addr, 16'h0000);
    check("rst_led", {8'h00, led}, 16'h0000);
    check("rst_txd", {15'h0, txd}, 16'h0001);
    check("rst_addr", addr_bus, 16'h0000);
    check("rst_strb", {13'h0, rdn, wr0n, wr1n}, 16'h0007);

    tick(); phases("ph_decode", 4'b0100);
    check("pc_hold_dec", rom_addr, 16'h0000);
    tick(); phases("ph_execute", 4'b0010);
    tick(); phases("ph_commit", 4'b0001);
    tick(); phases("ph_fetch2", 4'b1000);
    check("pc_1", rom_addr, 16'h0001);
    step_instr();
    check("pc_2", rom_addr, 16'h0002);
    step_instr();
    check("led_34", {8'h00, led}, 16'h0034);

    ints[3] = 1'b1;
    step_instr();                              // LDI r2
    ints[3] = 1'b0;
    step_instr(); step_instr(); step_instr();  // LDI r3, ADD, OUT
    check("led_0c", {8'h00, led}, 16'h000C);
    step_instr();                              // LDI r4
    st_check("st_r1", 16'h1234);

    tick(); tick();                            // LD in EXECUTE
    check("ld_addr", addr_bus, 16'h0040);
    check("ld_strb", {13'h0, rdn, wr0n, wr1n}, 16'h0003);
    tick(); tick();
    st_check("st_r5", 16'hBEEF);

    step_instr(); step_instr();                // LDI r8, SUB
    st_check("st_r7", 16'hFFFF);
    step_instr();
    check("led_ff", {8'h00, led}, 16'h00FF);
    step_instr();                              // JMP 020
    check("pc_jmp", rom_addr, 16'h0020);

    step_instr();
    st_check("st_dip", 16'h0005);
    step_instr();
    st_check("st_int", exp_int);
    step_instr();
    st_check("st_int2", 16'h0000);

    step_instr();                              // LDI r10
    step_instr();
    check("pc_jz_nt", rom_addr, 16'h0028);
    step_instr();
    check("pc_jz_t", rom_addr, 16'h0030);
    step_instr();
    check("pc_halt", rom_addr, 16'h0010);
    step_instr();                              // HALT
    phases("halt_ph", 4'b0000);
    tick(); tick(); tick();
    phases("halt_ph_stay", 4'b0000);
    check("halt_pc", rom_addr, 16'h0010);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    phases("rst2_phase", 4'b1000);
    check("rst2_pc", rom_addr, 16'h0000);
    check("rst2_led", {8'h00, led}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
